eq_band_mixer: RTL and testbench

//  Parametrised back end of the EQ datapath. It takes NUM_BANDS stereo band outputs from the FIR bank and applies a per-band pot gain to each.
//  It sums the bands with saturation, then applies a ramped (zipper-free) master volume with mute, and emits one stereo sample per input strobe with a valid.
//  Any band may be flagged as half-rate: it is captured only on every second strobe.

---
 rtl/eq_band_mixer.sv | 161 ++++++++++++++++
 tb/tb_eq_band_mixer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: per-band pot gain, saturating band sum and ramped master volume.
// Three register stages (capture, scaled, output) give a fixed 3-cycle latency.
module eq_band_mixer #(
    parameter int NUM_BANDS = 5,
    parameter int DW        = 16,
    parameter int POT_W     = 12,
    parameter int VOL_STEP  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       smpl_vld,
    input  logic [NUM_BANDS-1:0]       band_slow,
    input  logic [NUM_BANDS*DW-1:0]    band_lft,
    input  logic [NUM_BANDS*DW-1:0]    band_rght,
    input  logic [NUM_BANDS*POT_W-1:0] band_pot,
    input  logic [POT_W-1:0]           volume,
    input  logic                       mute,
    output logic [DW-1:0]              aud_out_lft,
    output logic [DW-1:0]              aud_out_rght,
    output logic                       out_vld,
    output logic                       clip
);
    localparam int PW = DW + POT_W + 1;
    localparam int SW = DW + $clog2(NUM_BANDS) + 1;
    localparam int MW = PW + SW;
    localparam logic [POT_W-1:0] STEP = POT_W'(VOL_STEP);

    // Clamp a sign-extended value to DW bits; the result MSB is the clip flag.
    function automatic logic [DW:0] sat(input logic [MW-1:0] x);
        logic [MW-DW:0] hi;
        hi = x[MW-1:DW-1];
        if ((&hi) || !(|hi)) sat = {1'b0, x[DW-1:0]};
        else if (x[MW-1])    sat = {2'b11, {(DW-1){1'b0}}};
        else                 sat = {2'b10, {(DW-1){1'b1}}};
    endfunction

    logic                    phase_q;
    logic [NUM_BANDS*DW-1:0] cap_l_q, cap_r_q;
    logic                    cap_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            cap_l_q   <= '0;
            cap_r_q   <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= smpl_vld;
            if (smpl_vld) begin
                phase_q <= ~phase_q;
                // Half-rate bands only refresh on the odd strobes and hold otherwise.
                for (int b = 0; b < NUM_BANDS; b++) begin
                    if (!band_slow[b] || phase_q) begin
                        cap_l_q[b*DW +: DW] <= band_lft[b*DW +: DW];
                        cap_r_q[b*DW +: DW] <= band_rght[b*DW +: DW];
                    end
                end
            end
        end
    end

    logic [NUM_BANDS*DW-1:0] scl_l_d, scl_r_d, scl_l_q, scl_r_q;
    logic                    c1_d, c1_q, s1_vld_q;

    always_comb begin
        logic signed [PW-1:0] gain, prod_l, prod_r;
        logic [DW:0]          sat_l, sat_r;
        scl_l_d = '0;
        scl_r_d = '0;
        c1_d    = 1'b0;
        gain    = '0;
        prod_l  = '0;
        prod_r  = '0;
        sat_l   = '0;
        sat_r   = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            gain   = PW'($signed({1'b0, band_pot[b*POT_W +: POT_W]}));
            prod_l = PW'($signed(cap_l_q[b*DW +: DW])) * gain;
            prod_r = PW'($signed(cap_r_q[b*DW +: DW])) * gain;
            sat_l  = sat(MW'(prod_l >>> (POT_W - 1)));
            sat_r  = sat(MW'(prod_r >>> (POT_W - 1)));
            scl_l_d[b*DW +: DW] = sat_l[DW-1:0];
            scl_r_d[b*DW +: DW] = sat_r[DW-1:0];
            c1_d = c1_d | sat_l[DW] | sat_r[DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_l_q  <= '0;
            scl_r_q  <= '0;
            c1_q     <= 1'b0;
            s1_vld_q <= 1'b0;
        end else begin
            scl_l_q  <= scl_l_d;
            scl_r_q  <= scl_r_d;
            c1_q     <= c1_d;
            s1_vld_q <= cap_vld_q;
        end
    end

    logic [POT_W-1:0] vol_cur_q, vol_cur_d, tgt;
    logic [DW-1:0]    out_l_d, out_r_d, out_l_q, out_r_q;
    logic             clip_d, clip_q, out_vld_q;

    // Band sum and master volume share the last stage; the multiply sees pre-update vol_cur.
    always_comb begin
        logic signed [SW-1:0] sum_l, sum_r;
        logic signed [PW-1:0] vgain, mul_l, mul_r;
        logic [DW:0]          s2_l, s2_r, s3_l, s3_r;
        sum_l = '0;
        sum_r = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            sum_l = sum_l + SW'($signed(scl_l_q[b*DW +: DW]));
            sum_r = sum_r + SW'($signed(scl_r_q[b*DW +: DW]));
        end
        s2_l    = sat(MW'(sum_l));
        s2_r    = sat(MW'(sum_r));
        vgain   = PW'($signed({1'b0, vol_cur_q}));
        mul_l   = PW'($signed(s2_l[DW-1:0])) * vgain;
        mul_r   = PW'($signed(s2_r[DW-1:0])) * vgain;
        s3_l    = sat(MW'(mul_l >>> POT_W));
        s3_r    = sat(MW'(mul_r >>> POT_W));
        out_l_d = s3_l[DW-1:0];
        out_r_d = s3_r[DW-1:0];
        clip_d  = c1_q | s2_l[DW] | s2_r[DW] | s3_l[DW] | s3_r[DW];
    end

    always_comb begin
        tgt       = mute ? '0 : volume;
        vol_cur_d = vol_cur_q;
        if (tgt > vol_cur_q) begin
            vol_cur_d = ((tgt - vol_cur_q) <= STEP) ? tgt : vol_cur_q + STEP;
        end else if (tgt < vol_cur_q) begin
            vol_cur_d = ((vol_cur_q - tgt) <= STEP) ? tgt : vol_cur_q - STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_l_q   <= '0;
            out_r_q   <= '0;
            clip_q    <= 1'b0;
            out_vld_q <= 1'b0;
            vol_cur_q <= '0;
        end else begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_l_q   <= out_l_d;
                out_r_q   <= out_r_d;
                clip_q    <= clip_d;
                vol_cur_q <= vol_cur_d;
            end
        end
    end

    assign aud_out_lft  = out_l_q;
    assign aud_out_rght = out_r_q;
    assign clip         = clip_q;
    assign out_vld      = out_vld_q;
endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: randomized traffic against an arithmetic
// reference model, plus hand-computed expectations for unity gain, saturation and ramp.
module tb_eq_band_mixer;
    localparam int NB       = 5;
    localparam int DW       = 16;
    localparam int POT_W    = 12;
    localparam int VOL_STEP = 16;
    localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (DW - 1));

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  smpl_vld = 1'b0;
    logic                  mute = 1'b0;
    logic [NB-1:0]         band_slow = '0;
    logic [NB*DW-1:0]      band_lft = '0;
    logic [NB*DW-1:0]      band_rght = '0;
    logic [NB*POT_W-1:0]   band_pot = '0;
    logic [POT_W-1:0]      volume = '0;
    logic [DW-1:0]         aud_out_lft, aud_out_rght;
    logic                  out_vld, clip;

    int testsRun = 0;
    int testsFailed = 0;

    eq_band_mixer #(.NUM_BANDS(NB), .DW(DW), .POT_W(POT_W), .VOL_STEP(VOL_STEP)) dut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .band_slow(band_slow),
        .band_lft(band_lft), .band_rght(band_rght), .band_pot(band_pot),
        .volume(volume), .mute(mute), .aud_out_lft(aud_out_lft),
        .aud_out_rght(aud_out_rght), .out_vld(out_vld), .clip(clip)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [NB*DW-1:0] l; logic [NB*DW-1:0] r; int cyc; } capT;
    typedef struct packed { int due; int l; int r; logic c; } expT;

    capT          capQ[$];
    expT          expQ[$];
    logic [NB*DW-1:0] mCapL = '0, mCapR = '0;
    bit           mPhase = 0;
    int           mVol = 0;
    int           cyc = 0;

    function automatic longint clampDw(input longint x, inout bit c);
        if (x > MAXV) begin c = 1; return MAXV; end
        if (x < MINV) begin c = 1; return MINV; end
        return x;
    endfunction

    function automatic longint mixChannel(input logic [NB*DW-1:0] cap, input logic [NB*POT_W-1:0] pots,
                                          input int vol, inout bit c);
        longint sum;
        longint x;
        longint g;
        sum = 0;
        for (int b = 0; b < NB; b++) begin
            x = longint'($signed(cap[b*DW +: DW]));
            g = longint'(pots[b*POT_W +: POT_W]);
            sum += clampDw((x * g) >>> (POT_W - 1), c);
        end
        sum = clampDw(sum, c);
        return clampDw((sum * longint'(vol)) >>> POT_W, c);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        capT s;
        bit  c;
        int  tgt, d;
        if (!rst_n) begin
            capQ.delete();
            expQ.delete();
            mCapL  = '0;
            mCapR  = '0;
            mPhase = 0;
            mVol   = 0;
        end else begin
            if (capQ.size() > 0 && capQ[0].cyc + 2 == cyc) begin
                s   = capQ.pop_front();
                c   = 0;
                tgt = mute ? 0 : int'(volume);
                expQ.push_back('{due: cyc + 1,
                                 l: int'(mixChannel(s.l, band_pot, mVol, c)),
                                 r: int'(mixChannel(s.r, band_pot, mVol, c)),
                                 c: c});
                d = tgt - mVol;
                if (d > VOL_STEP) d = VOL_STEP;
                if (d < -VOL_STEP) d = -VOL_STEP;
                mVol += d;
            end
            if (smpl_vld) begin
                for (int b = 0; b < NB; b++) begin
                    if (!band_slow[b] || mPhase) begin
                        mCapL[b*DW +: DW] = band_lft[b*DW +: DW];
                        mCapR[b*DW +: DW] = band_rght[b*DW +: DW];
                    end
                end
                mPhase = !mPhase;
                capQ.push_back('{l: mCapL, r: mCapR, cyc: cyc});
            end
            cyc++;
        end
    end

    always @(negedge clk) begin : compare
        bit  expV;
        expT e;
        expV = (expQ.size() > 0 && expQ[0].due == cyc);
        checkOutput("out_vld", longint'(out_vld), longint'(expV));
        if (expV) begin
            e = expQ.pop_front();
            checkOutput("aud_out_lft", longint'($signed(aud_out_lft)), longint'(e.l));
            checkOutput("aud_out_rght", longint'($signed(aud_out_rght)), longint'(e.r));
            checkOutput("clip", longint'(clip), longint'(e.c));
        end
    end

    bit logEn = 0;
    int logQ[$];
    always @(negedge clk) begin
        if (logEn && out_vld) logQ.push_back(int'($signed(aud_out_lft)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            smpl_vld = 1'b1;
            @(negedge clk);
        end
        smpl_vld = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic singleSample(output int l, output int r, output bit c, output bit v);
        smpl_vld = 1'b1;
        @(negedge clk);
        smpl_vld = 1'b0;
        repeat (2) @(negedge clk);
        l = int'($signed(aud_out_lft));
        r = int'($signed(aud_out_rght));
        c = clip;
        v = out_vld;
        repeat (2) @(negedge clk);
    endtask

    task automatic setAll(input logic [DW-1:0] smp, input logic [POT_W-1:0] pot);
        for (int b = 0; b < NB; b++) begin
            band_lft[b*DW +: DW]     = smp;
            band_rght[b*DW +: DW]    = smp;
            band_pot[b*POT_W +: POT_W] = pot;
        end
    endtask

    function automatic logic [DW-1:0] rndSample();
        int t;
        case ($urandom_range(0, 4))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: begin t = int'($urandom_range(0, 2000)) - 1000; return t[DW-1:0]; end
            default: begin t = int'($urandom); return t[DW-1:0]; end
        endcase
    endfunction

    initial begin
        int l, r, pre, vcount;
        bit c, v;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset out_vld", longint'(out_vld), 0);
        checkOutput("reset lft", longint'(aud_out_lft), 0);
        checkOutput("reset rght", longint'(aud_out_rght), 0);
        checkOutput("reset clip", longint'(clip), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp up from power-up: with a band sum of 4096 the output equals vol_cur.
        $display("[TB] ramp test");
        setAll('0, 12'h800);
        band_lft[DW-1:0]  = 16'd4096;
        band_rght[DW-1:0] = 16'hF000;
        volume = 12'hFFF;
        logQ.delete();
        logEn = 1;
        applyStimulus(300);
        logEn = 0;
        checkOutput("ramp up count", logQ.size(), 300);
        if (logQ.size() == 300) begin
            checkOutput("ramp k=1", logQ[0], 0);
            checkOutput("ramp k=2", logQ[1], 16);
            checkOutput("ramp k=101", logQ[100], 1600);
            checkOutput("ramp k=256", logQ[255], 4080);
            checkOutput("ramp k=257", logQ[256], 4095);
            checkOutput("ramp k=300", logQ[299], 4095);
        end
        checkOutput("ramp right mirror", longint'($signed(aud_out_rght)), -4095);

        mute = 1'b1;
        logQ.delete();
        logEn = 1;
        applyStimulus(300);
        logEn = 0;
        checkOutput("mute count", logQ.size(), 300);
        if (logQ.size() == 300) begin
            checkOutput("mute k=1", logQ[0], 4095);
            checkOutput("mute k=2", logQ[1], 4079);
            checkOutput("mute k=256", logQ[255], 15);
            checkOutput("mute k=257", logQ[256], 0);
            checkOutput("mute k=300", logQ[299], 0);
        end
        mute = 1'b0;
        applyStimulus(300);

        // Unity pots, full volume
        $display("[TB] unity test");
        setAll('0, 12'h800);
        band_lft[DW-1:0] = 16'd1000;
        singleSample(l, r, c, v);
        checkOutput("unity vld", longint'(v), 1);
        checkOutput("unity +1000", l, 999);
        checkOutput("unity clip", longint'(c), 0);
        band_lft[DW-1:0] = 16'hFC18;
        singleSample(l, r, c, v);
        checkOutput("unity -1000", l, -1000);

        // Saturation at every stage
        $display("[TB] saturation test");
        setAll(16'h7FFF, 12'hFFF);
        singleSample(l, r, c, v);
        checkOutput("sat pos lft", l, 32759);
        checkOutput("sat pos clip", longint'(c), 1);
        setAll(16'h8000, 12'hFFF);
        singleSample(l, r, c, v);
        checkOutput("sat neg lft", l, -32760);
        checkOutput("sat neg rght", r, -32760);
        checkOutput("sat neg clip", longint'(c), 1);

        // Back-to-back strobes keep order and exact 3-cycle latency
        $display("[TB] latency test");
        setAll('0, 12'h800);
        band_lft[DW-1:0] = 16'd100;
        smpl_vld = 1'b1;
        @(negedge clk);
        band_lft[DW-1:0] = 16'd200;
        @(negedge clk);
        checkOutput("latency early vld", longint'(out_vld), 0);
        band_lft[DW-1:0] = 16'd300;
        @(negedge clk);
        smpl_vld = 1'b0;
        checkOutput("latency vld1", longint'(out_vld), 1);
        checkOutput("latency val1", longint'($signed(aud_out_lft)), 99);
        @(negedge clk);
        checkOutput("latency vld2", longint'(out_vld), 1);
        checkOutput("latency val2", longint'($signed(aud_out_lft)), 199);
        @(negedge clk);
        checkOutput("latency vld3", longint'(out_vld), 1);
        checkOutput("latency val3", longint'($signed(aud_out_lft)), 299);
        @(negedge clk);
        checkOutput("latency vld off", longint'(out_vld), 0);
        repeat (3) @(negedge clk);

        // Half-rate band0 with band0 changing every strobe
        $display("[TB] half-rate test");
        band_slow = 5'b00001;
        for (int i = 0; i < 24; i++) begin
            band_lft[DW-1:0]    = DW'(i * 500 + 7);
            band_rght[DW-1:0]   = DW'(i * 300 + 3);
            band_lft[DW +: DW]  = DW'(i * 11);
            smpl_vld = 1'b1;
            @(negedge clk);
        end
        smpl_vld = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized bursts; pots only change while the pipeline is empty
        $display("[TB] random test");
        for (int burst = 0; burst < 40; burst++) begin
            for (int b = 0; b < NB; b++) begin
                band_pot[b*POT_W +: POT_W] = ($urandom_range(0, 1) == 0) ? 12'h800 : POT_W'($urandom);
            end
            band_slow = NB'($urandom);
            volume = POT_W'($urandom);
            mute = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 40; i++) begin
                smpl_vld = ($urandom_range(0, 99) < 70);
                for (int b = 0; b < NB; b++) begin
                    band_lft[b*DW +: DW]  = rndSample();
                    band_rght[b*DW +: DW] = rndSample();
                end
                if ($urandom_range(0, 19) == 0) volume = POT_W'($urandom);
                if ($urandom_range(0, 29) == 0) mute = ~mute;
                if ($urandom_range(0, 9) == 0) band_slow = NB'($urandom);
                @(negedge clk);
            end
            smpl_vld = 1'b0;
            repeat (4) @(negedge clk);
        end

        // Asynchronous reset with two samples in flight
        $display("[TB] reset test");
        band_slow = '0;
        mute = 1'b0;
        volume = 12'hFFF;
        setAll(16'h1234, 12'h800);
        pre = int'(out_vld);
        smpl_vld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        smpl_vld = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst out_vld", longint'(out_vld), 0);
        checkOutput("async rst lft", longint'(aud_out_lft), 0);
        checkOutput("async rst rght", longint'(aud_out_rght), 0);
        checkOutput("async rst clip", longint'(clip), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vcount += int'(out_vld);
        end
        checkOutput("no vld after reset", vcount, 0);
        singleSample(l, r, c, v);
        checkOutput("post reset vld", longint'(v), 1);
        checkOutput("post reset muted lft", l, 0);
        repeat (4) @(negedge clk);
        checkOutput("model drained", expQ.size() + capQ.size(), 0);
        if (pre < 0) $display("[TB] unreachable");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
